// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-flop synchronizer, press/release debounce FSM,
// registered press/release/short/long event pulses.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PB_SW,
  output logic PB_LEVEL,
  output logic PB_PRESS,
  output logic PB_RELEASE,
  output logic PB_SHORT,
  output logic PB_LONG
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_ONE  = LG_W'(1);
  localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYCLES);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
  localparam logic IDLE_RAW = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [LG_W-1:0] hold_q, hold_d;
  logic long_fired_q, long_fired_d;
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic pressed;

  // Only the second synchronizer stage feeds the FSM, normalized to 1 = pressed
  assign pressed = sync2_q ^ IDLE_RAW;

  always_comb begin
    sync1_d      = PB_SW;
    sync2_d      = sync1_q;
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    hold_d       = hold_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    short_d      = 1'b0;
    long_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        db_cnt_d = '0;
        if (pressed) begin
          state_d  = PRESS_DB;
          db_cnt_d = DB_ONE;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = HELD;
          db_cnt_d     = '0;
          hold_d       = '0;
          long_fired_d = 1'b0;
          level_d      = 1'b1;
          press_d      = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d  = RELEASE_DB;
          db_cnt_d = DB_ONE;
        end else if (hold_q != LG_MAX) begin
          hold_d = hold_q + LG_ONE;
          if (hold_q == LG_LAST && !long_fired_q) begin
            long_d       = 1'b1;
            long_fired_d = 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = IDLE;
          db_cnt_d     = '0;
          level_d      = 1'b0;
          release_d    = 1'b1;
          short_d      = !long_fired_q;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      db_cnt_q     <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      sync1_q      <= IDLE_RAW;
      sync2_q      <= IDLE_RAW;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      short_q      <= short_d;
      long_q       <= long_d;
    end
  end

  assign PB_LEVEL   = level_q;
  assign PB_PRESS   = press_q;
  assign PB_RELEASE = release_q;
  assign PB_SHORT   = short_q;
  assign PB_LONG    = long_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboarded bench for pb_debounce: expected pulse events are queued
// by the stimulus and checked by an independent output monitor.
module tb_pb_debounce;

  logic CLK;
  logic RESET;
  logic PB_SW;
  logic PB_LEVEL;
  logic PB_PRESS;
  logic PB_RELEASE;
  logic PB_SHORT;
  logic PB_LONG;

  pb_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .PB_SW(PB_SW),
    .PB_LEVEL(PB_LEVEL),
    .PB_PRESS(PB_PRESS),
    .PB_RELEASE(PB_RELEASE),
    .PB_SHORT(PB_SHORT),
    .PB_LONG(PB_LONG)
  );

  typedef struct {
    int       cyc;
    logic [3:0] p;
    logic     lvl;
  } ev_t;

  ev_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  logic [4:0] outs;

  assign outs = {PB_LEVEL, PB_PRESS, PB_RELEASE, PB_SHORT, PB_LONG};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_n <= edge_n + 1;

  // pulse vector order: {PRESS, RELEASE, SHORT, LONG}
  always @(negedge CLK) begin
    logic [3:0] p;
    ev_t e;
    p = {PB_PRESS, PB_RELEASE, PB_SHORT, PB_LONG};
    if (p != 4'b0000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: edge %0d pulses %b level %b, none expected",
                 edge_n, p, PB_LEVEL);
      end else begin
        e = sb.pop_front();
        if (e.cyc != edge_n || e.p != p || e.lvl != PB_LEVEL) begin
          n_bad++;
          $display("FAIL event: got edge %0d pulses %b level %b, expected edge %0d pulses %b level %b",
                   edge_n, p, PB_LEVEL, e.cyc, e.p, e.lvl);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int cyc, input logic [3:0] p, input logic lvl);
    ev_t e;
    e.cyc = cyc;
    e.p   = p;
    e.lvl = lvl;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, queue %0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RESET = 1'b0;
    PB_SW = 1'b0;
    #1 RESET = 1'b1;
    #1 chk("reset_async_outs", 32'(outs), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset_outs", 32'(outs), 0);
    end
    PB_SW = 1'b1;
    wait_neg(2);
    RESET = 1'b0;
    wait_neg(8);
    chk("idle_outs", 32'(outs), 0);

    // clean press, short release
    n = edge_n;
    PB_SW = 1'b0;
    expect_ev(n + 6, 4'b1000, 1'b1);
    wait_neg(5);
    chk("clean_lvl_before", 32'(PB_LEVEL), 0);
    wait_neg(1);
    chk("clean_lvl_after", 32'(PB_LEVEL), 1);
    wait_neg(10);
    n = edge_n;
    PB_SW = 1'b1;
    expect_ev(n + 6, 4'b0110, 1'b0);
    wait_neg(5);
    chk("short_lvl_before", 32'(PB_LEVEL), 1);
    wait_neg(1);
    chk("short_lvl_after", 32'(PB_LEVEL), 0);
    wait_neg(10);
    chk("drain_short", 32'(sb.size()), 0);

    // bouncing press
    n = edge_n;
    PB_SW = 1'b0;
    expect_ev(n + 10, 4'b1000, 1'b1);
    wait_neg(3);
    PB_SW = 1'b1;
    wait_neg(1);
    PB_SW = 1'b0;
    wait_neg(5);
    chk("bounce_lvl_before", 32'(PB_LEVEL), 0);
    wait_neg(1);
    chk("bounce_lvl_after", 32'(PB_LEVEL), 1);
    wait_neg(10);
    n = edge_n;
    PB_SW = 1'b1;
    expect_ev(n + 6, 4'b0110, 1'b0);
    wait_neg(12);
    chk("drain_bounce", 32'(sb.size()), 0);

    // long press
    n = edge_n;
    PB_SW = 1'b0;
    expect_ev(n + 6, 4'b1000, 1'b1);
    expect_ev(n + 26, 4'b0001, 1'b1);
    wait_neg(30);
    n = edge_n;
    PB_SW = 1'b1;
    expect_ev(n + 6, 4'b0100, 1'b0);
    wait_neg(12);
    chk("drain_long", 32'(sb.size()), 0);
    chk("long_lvl_idle", 32'(PB_LEVEL), 0);

    // release glitch in HELD, then reset while held
    n = edge_n;
    PB_SW = 1'b0;
    expect_ev(n + 6, 4'b1000, 1'b1);
    wait_neg(10);
    PB_SW = 1'b1;
    wait_neg(2);
    PB_SW = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("glitch_lvl", 32'(PB_LEVEL), 1);
      wait_neg(1);
    end
    chk("drain_glitch", 32'(sb.size()), 0);
    RESET = 1'b1;
    #1 chk("held_reset_outs", 32'(outs), 0);
    wait_neg(3);
    chk("held_reset_hold", 32'(outs), 0);
    n = edge_n;
    RESET = 1'b0;
    expect_ev(n + 6, 4'b1000, 1'b1);
    wait_neg(5);
    chk("rearm_lvl_before", 32'(PB_LEVEL), 0);
    wait_neg(1);
    chk("rearm_lvl_after", 32'(PB_LEVEL), 1);
    wait_neg(5);
    n = edge_n;
    PB_SW = 1'b1;
    expect_ev(n + 6, 4'b0110, 1'b0);
    wait_neg(12);
    chk("drain_final", 32'(sb.size()), 0);
    chk("final_outs", 32'(outs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
